// File: rtl/red_seq_unit.sv
// Sequential lane-sum reduction: adds one lane pair of two operands per cycle; result after NUM_LANES edges.
// Latency NUM_LANES edges from accept to out_valid; in_ready low while busy, RESULT held until out_ready.
module red_seq_unit #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int ACC_W     = LANE_W + $clog2(2 * NUM_LANES) + 1;
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic        [ACC_W-1:0] U_MAX = ACC_W'((2 ** LANE_W) - 1);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (LANE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2 ** (LANE_W - 1)));

  typedef enum logic [1:0] {IDLE, SUM, RESULT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [1:0]          mode_q, mode_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;

  logic [LANE_W-1:0]   lane_a, lane_b;
  logic [ACC_W-1:0]    ext_a, ext_b, sum;
  logic                sgn;
  logic [OUT_W-1:0]    res_data;
  logic                res_ovf;

  // Datapath: the sum including the current lane, and the mode-dependent result view of it.
  always_comb begin
    lane_a = a_q[idx_q * LANE_W +: LANE_W];
    lane_b = b_q[idx_q * LANE_W +: LANE_W];
    sgn    = (mode_q == 2'b10);
    ext_a  = sgn ? {{(ACC_W - LANE_W){lane_a[LANE_W-1]}}, lane_a}
                 : {{(ACC_W - LANE_W){1'b0}}, lane_a};
    ext_b  = sgn ? {{(ACC_W - LANE_W){lane_b[LANE_W-1]}}, lane_b}
                 : {{(ACC_W - LANE_W){1'b0}}, lane_b};
    sum    = acc_q + ext_a + ext_b;

    res_data = '0;
    res_ovf  = 1'b0;
    case (mode_q)
      2'b00: begin
        res_data = OUT_W'(sum[LANE_W-1:0]);
        res_ovf  = (sum > U_MAX);
      end
      2'b01: begin
        res_data = OUT_W'(sum);
        res_ovf  = 1'b0;
      end
      2'b10: begin
        res_data = OUT_W'($signed(sum));
        res_ovf  = ($signed(sum) < S_MIN) || ($signed(sum) > S_MAX);
      end
      default: begin
        res_ovf  = (sum > U_MAX);
        res_data = res_ovf ? OUT_W'(U_MAX) : OUT_W'(sum);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_LANES - 1)) begin
          out_data_d = res_data;
          out_ovf_d  = res_ovf;
          state_d    = RESULT;
        end
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 2'b00;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_red_seq_unit.sv
// Directed bench for red_seq_unit: default 16/4 instance with hand-computed vectors, plus a 32/8 instance vs a lane-sum model.
module tb_red_seq_unit;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_a, in_b, out_data;
  logic [1:0]  mode;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
  logic [31:0] in_a2, in_b2;
  logic [15:0] out_data2;
  logic [1:0]  mode2;

  int checks   = 0;
  int failures = 0;

  red_seq_unit #(.DATA_W(16), .LANE_W(4), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  red_seq_unit #(.DATA_W(32), .LANE_W(8), .OUT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .mode(mode2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_ovf(out_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference for the 32-bit / 8-bit-lane instance.
  function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                  output logic [15:0] d, output logic o);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (m == 2'b10) s += int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
      else            s += int'(a[8*i +: 8]) + int'(b[8*i +: 8]);
    end
    case (m)
      2'b00:   begin d = 16'(s & 255); o = (s > 255); end
      2'b01:   begin d = 16'(s);       o = 1'b0; end
      2'b10:   begin d = 16'(s);       o = (s < -128) || (s > 127); end
      default: begin o = (s > 255);    d = o ? 16'd255 : 16'(s); end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input logic [15:0] ed, input logic eo, input bit clobber);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; mode = m;
    @(negedge clk);
    in_valid = 1'b0;
    if (clobber) begin
      in_a = 16'h0000; in_b = 16'hFFFF; mode = 2'b01;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_ovf"}, out_ovf, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_vld_drop"}, out_valid, 0);
  endtask

  task automatic run_op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int n;
    logic [15:0] ed;
    logic        eo;
    model32(a, b, m, ed, eo);
    @(negedge clk);
    in_valid2 = 1'b1; in_a2 = a; in_b2 = b; mode2 = m;
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_data"}, out_data2, ed);
    chk({tag, "_ovf"}, out_ovf2, eo);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk({tag, "_idle"}, in_ready2, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; mode = 2'b00; out_ready = 1'b0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; mode2 = 2'b00; out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_rdy32", in_ready2, 1);
    rst_n = 1'b1;

    run_op("basic",  16'h1234, 16'h1111, 2'b00, 16'h000E, 1'b0, 1'b0);
    run_op("ff_m00", 16'hFFFF, 16'hFFFF, 2'b00, 16'h0008, 1'b1, 1'b0);
    run_op("ff_m01", 16'hFFFF, 16'hFFFF, 2'b01, 16'h0078, 1'b0, 1'b0);
    run_op("ff_m11", 16'hFFFF, 16'hFFFF, 2'b11, 16'h000F, 1'b1, 1'b0);
    run_op("ff_m10", 16'hFFFF, 16'hFFFF, 2'b10, 16'hFFF8, 1'b0, 1'b0);
    run_op("s77_m10", 16'h7777, 16'h7777, 2'b10, 16'h0038, 1'b1, 1'b0);
    run_op("zero_m10", 16'h0000, 16'h0000, 2'b10, 16'h0000, 1'b0, 1'b0);
    run_op("zero_m11", 16'h0000, 16'h0000, 2'b11, 16'h0000, 1'b0, 1'b0);
    run_op("clobber", 16'h1234, 16'h1111, 2'b00, 16'h000E, 1'b0, 1'b1);
    in_a = '0; in_b = '0; mode = 2'b00;

    // Stall in RESULT with a competing request that must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; mode = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_lat", n, 4);
    for (int i = 0; i < 3; i++) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_data", out_data, 16'h000F);
      chk("hold_ovf", out_ovf, 1);
      chk("hold_rdy", in_ready, 0);
      if (i == 1) begin
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h1111; mode = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("hold_after_data", out_data, 16'h000F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rel_rdy", in_ready, 1);
    chk("hold_rel_vld", out_valid, 0);
    @(negedge clk);
    chk("hold_no_capture", in_ready, 1);

    // Asynchronous reset while the second lane is being summed.
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ovf", out_ovf, 0);
    chk("arst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_result", out_valid, 0);
    run_op("post_rst", 16'h1234, 16'h1111, 2'b00, 16'h000E, 1'b0, 1'b0);

    // Wider instance: every mode over fixed, zero and random operands.
    for (int m = 0; m < 4; m++) begin
      run_op32("w_zero", 32'h0, 32'h0, 2'(m));
      run_op32("w_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(m));
      run_op32("w_7f", 32'h7F7F_7F7F, 32'h7F7F_7F7F, 2'(m));
      run_op32("w_80", 32'h8080_8080, 32'h8080_8080, 2'(m));
      run_op32("w_small", 32'h0102_0304, 32'h0001_0203, 2'(m));
      for (int r = 0; r < 4; r++) begin
        run_op32("w_rand", $urandom, $urandom, 2'(m));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
